// File: rtl/key_filter.sv
// Debouncer for one raw active-low push-button: 2-FF synchroniser, 4-state filter FSM
// and one shared counter, producing registered press/release/long-press pulses.
module key_filter #(
    parameter int unsigned CNT_MAX  = 999_999,
    parameter int unsigned LONG_MAX = 49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_rel_flag,
    output logic key_long_flag,
    output logic key_state
);

    localparam int unsigned CW = $clog2(LONG_MAX + 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CNT_MAX);
    localparam logic [CW-1:0] LONG_END = CW'(LONG_MAX);

    typedef enum logic [1:0] {
        IDLE,
        FILT_DN,
        PRESSED,
        FILT_UP
    } state_t;

    logic [1:0]    sync_q, sync_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          long_done_q, long_done_d;
    logic          key_flag_q, key_flag_d;
    logic          key_rel_flag_q, key_rel_flag_d;
    logic          key_long_flag_q, key_long_flag_d;
    logic          key_state_q, key_state_d;
    logic          key_sync;

    assign key_sync = sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], key_in};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            long_done_q     <= 1'b0;
            key_flag_q      <= 1'b0;
            key_rel_flag_q  <= 1'b0;
            key_long_flag_q <= 1'b0;
            key_state_q     <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            long_done_q     <= long_done_d;
            key_flag_q      <= key_flag_d;
            key_rel_flag_q  <= key_rel_flag_d;
            key_long_flag_q <= key_long_flag_d;
            key_state_q     <= key_state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        long_done_d     = long_done_q;
        key_flag_d      = 1'b0;
        key_rel_flag_d  = 1'b0;
        key_long_flag_d = 1'b0;
        key_state_d     = key_state_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!key_sync) begin
                    state_d = FILT_DN;
                end
            end

            FILT_DN: begin
                if (key_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_END) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    long_done_d = 1'b0;
                    key_flag_d  = 1'b1;
                    key_state_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PRESSED: begin
                if (key_sync) begin
                    state_d = FILT_UP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_END) begin
                    // Counter parks at the threshold; long_done blocks a repeat pulse.
                    if (!long_done_q) begin
                        key_long_flag_d = 1'b1;
                        long_done_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            FILT_UP: begin
                if (!key_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_END) begin
                    state_d        = IDLE;
                    cnt_d          = '0;
                    key_rel_flag_d = 1'b1;
                    key_state_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_flag      = key_flag_q;
    assign key_rel_flag  = key_rel_flag_q;
    assign key_long_flag = key_long_flag_q;
    assign key_state     = key_state_q;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed press/bounce/long/reset scenarios plus random key
// activity, each cycle checked against a run-length model of the debounced button.
module tb_key_filter;

    localparam int unsigned CNT_MAX  = 4;
    localparam int unsigned LONG_MAX = 20;

    logic sys_clk;
    logic sys_rst;
    logic key_in;
    logic key_flag;
    logic key_rel_flag;
    logic key_long_flag;
    logic key_state;

    int compared   = 0;
    int mismatched = 0;

    // Model: inputs reach the filter two clocks late; a level change is accepted after
    // CNT_MAX+2 consecutive opposite samples; a long press needs LONG_MAX+1 held samples.
    bit q_s[$];
    int opp_run;
    int hold;
    bit lvl;
    bit lfired;
    bit e_flag, e_rel, e_long;

    key_filter #(
        .CNT_MAX (CNT_MAX),
        .LONG_MAX(LONG_MAX)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_in       (key_in),
        .key_flag     (key_flag),
        .key_rel_flag (key_rel_flag),
        .key_long_flag(key_long_flag),
        .key_state    (key_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model(input bit k, input bit r);
        bit s;
        e_flag = 1'b0;
        e_rel  = 1'b0;
        e_long = 1'b0;
        if (r) begin
            q_s     = {1'b1, 1'b1};
            lvl     = 1'b1;
            opp_run = 0;
            hold    = 0;
            lfired  = 1'b0;
        end else begin
            s = q_s.pop_front();
            q_s.push_back(k);
            if (s != lvl) begin
                opp_run++;
                if (lvl == 1'b0) hold = 0;
                if (opp_run == int'(CNT_MAX) + 2) begin
                    lvl     = s;
                    opp_run = 0;
                    hold    = 0;
                    if (s == 1'b0) begin
                        e_flag = 1'b1;
                        lfired = 1'b0;
                    end else begin
                        e_rel = 1'b1;
                    end
                end
            end else begin
                if (lvl == 1'b0) begin
                    if (opp_run > 0) begin
                        hold = 0;
                    end else begin
                        hold++;
                        if (hold == int'(LONG_MAX) + 1 && !lfired) begin
                            e_long = 1'b1;
                            lfired = 1'b1;
                        end
                    end
                end
                opp_run = 0;
            end
        end
    endtask

    task automatic step(input logic k, input logic r);
        key_in  = k;
        sys_rst = r;
        @(posedge sys_clk);
        model(k, r);
        #1;
        chk("key_flag", key_flag, e_flag);
        chk("key_rel_flag", key_rel_flag, e_rel);
        chk("key_long_flag", key_long_flag, e_long);
        chk("key_state", key_state, lvl);
    endtask

    initial begin
        logic [6:0] bounce;
        logic [2:0] rel_pat;
        int         len;
        logic       lv;

        key_in  = 1'b1;
        sys_rst = 1'b1;

        // Reset with the key held down, then a full debounce from reset release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("rst_state", key_state, 1'b1);
        chk("rst_flag", key_flag | key_rel_flag | key_long_flag, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            chk("s1_flag_time", key_flag, 1'(i == 7));
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            chk("s1_rel_time", key_rel_flag, 1'(i == 7));
        end

        // Bounced press is rejected.
        bounce = 7'b1001000;
        for (int i = 0; i < 17; i++) begin
            step((i < 7) ? bounce[6 - i] : 1'b1, 1'b0);
            chk("s2_no_flag", key_flag, 1'b0);
            chk("s2_state", key_state, 1'b1);
        end

        // Clean press held into a long press.
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0);
            chk("s3_flag_time", key_flag, 1'(i == 7));
            chk("s3_state", key_state, 1'(i < 7));
            chk("s4_long_time", key_long_flag, 1'(i == 28));
        end

        // Release with a bounce.
        rel_pat = 3'b110;
        for (int i = 0; i < 14; i++) begin
            step((i < 3) ? rel_pat[2 - i] : 1'b1, 1'b0);
            chk("s5_rel_time", key_rel_flag, 1'(i == 10));
            chk("s5_no_flag", key_flag, 1'b0);
        end

        // Reset while pressed, key kept down.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("s6_rst_state", key_state, 1'b1);
        chk("s6_rst_flag", key_flag | key_rel_flag | key_long_flag, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            chk("s6_flag_time", key_flag, 1'(i == 7));
            chk("s6_no_rel", key_rel_flag, 1'b0);
        end

        // Random bursts with bounce and occasional reset.
        for (int n = 0; n < 150; n++) begin
            lv  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            for (int c = 0; c < len; c++) begin
                step(($urandom_range(0, 7) == 0) ? ~lv : lv,
                     1'($urandom_range(0, 199) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
